simon_decrypt: RTL

// - Simon 128/256 block decryptor and consumer of the round-key stream from the key schedule generator.
// - Captures the 72 round keys k0..k71 in order into a local key buffer.
// - Decrypts 128-bit ciphertext blocks by running the inverse round k71 -> k0, one round per cycle.
// - Sits beside the encrypt datapath. Keys are loaded once per key change; any number of blocks follow.

---
 rtl/simon_pkg.sv | 28 ++
 rtl/simon_decrypt_if.sv | 29 ++
 rtl/simon_key_ram.sv | 24 ++
 rtl/simon_decrypt.sv | 100 ++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared Simon 128/256 definitions for the encrypt and decrypt datapaths.
// Holds the geometry, the controller state type and the round function.
package simon_pkg;

    localparam int WORD   = 64;
    localparam int ROUNDS = 72;
    localparam int RW     = $clog2(ROUNDS);

    typedef enum logic [2:0] {
        EMPTY,
        LOAD,
        IDLE,
        RUN,
        DONE
    } state_t;

    // f(v) = (v <<< 1 & v <<< 8) ^ v <<< 2
    function automatic logic [WORD-1:0] simon_f(input logic [WORD-1:0] v);
        logic [WORD-1:0] r1;
        logic [WORD-1:0] r2;
        logic [WORD-1:0] r8;
        r1 = {v[WORD-2:0], v[WORD-1]};
        r2 = {v[WORD-3:0], v[WORD-1:WORD-2]};
        r8 = {v[WORD-9:0], v[WORD-1:WORD-8]};
        return (r1 & r8) ^ r2;
    endfunction

endpackage

// File: rtl/simon_decrypt_if.sv
// Key stream, ciphertext and plaintext handshakes of the Simon decryptor.
// The master side is the key schedule / block producer / consumer.
interface simon_decrypt_if;
    import simon_pkg::*;

    logic                key_load;
    logic                key_valid;
    logic [WORD-1:0]     key_in;
    logic                keys_ready;
    logic                ct_valid;
    logic                ct_ready;
    logic [2*WORD-1:0]   ct_in;
    logic                pt_valid;
    logic                pt_ready;
    logic [2*WORD-1:0]   pt_out;

    modport master (
        output key_load, key_valid, key_in,
        output ct_valid, ct_in, pt_ready,
        input  keys_ready, ct_ready, pt_valid, pt_out
    );

    modport slave (
        input  key_load, key_valid, key_in,
        input  ct_valid, ct_in, pt_ready,
        output keys_ready, ct_ready, pt_valid, pt_out
    );

endinterface

// File: rtl/simon_key_ram.sv
// Round-key register file: one synchronous write port, one combinational
// read port. Contents are not reset; the controller tracks validity.
module simon_key_ram
    import simon_pkg::*;
(
    input  logic            clk,
    input  logic            i_we,
    input  logic [RW-1:0]   i_waddr,
    input  logic [WORD-1:0] i_wdata,
    input  logic [RW-1:0]   i_raddr,
    output logic [WORD-1:0] o_rdata
);

    logic [WORD-1:0] r_mem [ROUNDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/simon_decrypt.sv
// Simon 128/256 iterative decryptor: captures 72 round keys, then runs
// the inverse round k71 -> k0 one round per cycle on each ciphertext.
module simon_decrypt
    import simon_pkg::*;
(
    input  logic          clk,
    input  logic          res,
    simon_decrypt_if.slave bus
);

    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_widx;
    logic [RW-1:0]   r_rnd;
    logic [WORD-1:0] r_x;
    logic [WORD-1:0] r_y;
    logic [WORD-1:0] w_key;
    logic            w_we;
    logic            w_accept;
    logic            w_step;

    simon_key_ram u_key_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_widx),
        .i_wdata (bus.key_in),
        .i_raddr (r_rnd),
        .o_rdata (w_key)
    );

    // key_load overrides every state, including a write in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        if (bus.key_load) begin
            w_state_nxt = LOAD;
        end else begin
            unique case (r_state)
                EMPTY: ;
                LOAD: begin
                    if (bus.key_valid) begin
                        w_we = 1'b1;
                        if (r_widx == LAST) w_state_nxt = IDLE;
                    end
                end
                IDLE: begin
                    if (bus.ct_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    w_step = 1'b1;
                    if (r_rnd == '0) w_state_nxt = DONE;
                end
                DONE: begin
                    if (bus.pt_ready) w_state_nxt = IDLE;
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= EMPTY;
            r_widx  <= '0;
            r_rnd   <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.key_load) begin
                r_widx <= '0;
            end else if (w_we) begin
                r_widx <= (r_widx == LAST) ? '0 : r_widx + 1'b1;
            end
            if (w_accept) begin
                r_x   <= bus.ct_in[2*WORD-1:WORD];
                r_y   <= bus.ct_in[WORD-1:0];
                r_rnd <= LAST;
            end else if (w_step) begin
                r_x <= r_y;
                r_y <= r_x ^ simon_f(r_y) ^ w_key;
                if (r_rnd != '0) r_rnd <= r_rnd - 1'b1;
            end
        end
    end

    assign bus.keys_ready = (r_state == IDLE) || (r_state == RUN) ||
                            (r_state == DONE);
    assign bus.ct_ready   = (r_state == IDLE);
    assign bus.pt_valid   = (r_state == DONE);
    assign bus.pt_out     = (r_state == DONE) ? {r_x, r_y} : '0;

endmodule
